// File: rtl/alu_chunk_sequencer_if.sv
// Bundle of the request, ALU-slice and response signals around the chunk
// sequencer. The master view belongs to the sequencer; the slave view is the
// surrounding environment (request source, ALU slice, response sink).
interface alu_chunk_sequencer_if #(
  parameter int WIDTH  = 3,
  parameter int CHUNKS = 4
);
  localparam int W = WIDTH * CHUNKS;

  // Operation request channel
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  logic             req_carryin;

  // Combinational ALU slice
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic             alu_carryin;
  logic [WIDTH-1:0] alu_result;
  logic             alu_c;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_result;
  logic             rsp_n;
  logic             rsp_z;
  logic             rsp_c;
  logic             rsp_v;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_carryin,
    output req_ready,
    output alu_a, alu_b, alu_control, alu_carryin,
    input  alu_result, alu_c,
    output rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_carryin,
    input  req_ready,
    input  alu_a, alu_b, alu_control, alu_carryin,
    output alu_result, alu_c,
    input  rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v,
    output rsp_ready
  );
endinterface

// File: rtl/alu_chunk_sequencer.sv
// Multi-cycle controller for a WIDTH-bit combinational ALU slice. A request of
// CHUNKS*WIDTH-bit operands is executed one slice per clock, lowest slice
// first. Add/sub chain the carry between slices; subtraction is issued as an
// add of ~b with carry-in 1. Full-width n/z/c/v flags are formed from the
// registered operands and result once all slices are stored.
module alu_chunk_sequencer #(
  parameter int WIDTH  = 3,
  parameter int CHUNKS = 4
) (
  input logic                   clk,
  input logic                   rst,
  alu_chunk_sequencer_if.master seq_if
);

  localparam int            W      = WIDTH * CHUNKS;
  localparam int            KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);
  localparam logic [2:0]    OP_ADD = 3'd0;
  localparam logic [2:0]    OP_SUB = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [2:0]       slice_ctrl;
  logic             slice_cin;
  logic             is_arith;
  logic             beff_msb;
  logic             done_out;

  // Signed overflow of a two-operand add, judged from the three sign bits.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign beff_msb = (op_q == OP_SUB) ? ~b_q[W-1] : b_q[W-1];

  // Register update; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  // Next-state logic and the slice drive presented to the ALU during RUN.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cin_d      = cin_q;
    result_d   = result_q;
    carry_d    = carry_q;
    slice_a    = '0;
    slice_b    = '0;
    slice_ctrl = '0;
    slice_cin  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (seq_if.req_valid) begin
          a_d     = seq_if.req_a;
          b_d     = seq_if.req_b;
          op_d    = seq_if.req_op;
          cin_d   = seq_if.req_carryin;
          k_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        slice_a = a_q[int'(k_q)*WIDTH +: WIDTH];
        slice_b = (op_q == OP_SUB) ? ~b_q[int'(k_q)*WIDTH +: WIDTH]
                                   :  b_q[int'(k_q)*WIDTH +: WIDTH];
        // Subtraction rides on the ALU adder.
        slice_ctrl = (op_q == OP_SUB) ? OP_ADD : op_q;
        if (is_arith) begin
          if (k_q == '0) begin
            slice_cin = (op_q == OP_SUB) ? 1'b1 : cin_q;
          end else begin
            slice_cin = carry_q;
          end
        end
        result_d[int'(k_q)*WIDTH +: WIDTH] = seq_if.alu_result;
        carry_d = seq_if.alu_c;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (seq_if.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign seq_if.req_ready   = (state_q == IDLE) && !rst;
  assign seq_if.alu_a       = rst ? '0   : slice_a;
  assign seq_if.alu_b       = rst ? '0   : slice_b;
  assign seq_if.alu_control = rst ? 3'd0 : slice_ctrl;
  assign seq_if.alu_carryin = !rst && slice_cin;

  assign done_out          = (state_q == DONE) && !rst;
  assign seq_if.rsp_valid  = done_out;
  assign seq_if.rsp_result = done_out ? result_q : '0;
  assign seq_if.rsp_n      = done_out && result_q[W-1];
  assign seq_if.rsp_z      = done_out && (result_q == '0);
  assign seq_if.rsp_c      = done_out && is_arith && carry_q;
  assign seq_if.rsp_v      = done_out && is_arith &&
                             add_overflow(a_q[W-1], beff_msb, result_q[W-1]);

endmodule
